aes_fifo_sequencer: RTL
=======================

AES_FIFO_SEQUENCER -- requirements
Module: aes_fifo_sequencer

Interface
REQ-001 Parameter: TIMEOUT, 255, max cycles waited for aes_done after aes_start.
REQ-002 Parameter: CNT_W, 16, width of blk_cnt.
REQ-003 Ports: clk  in  1  single clock, all logic on rising edge.
REQ-004 Ports: rst  in  1  reset, asynchronous, active-high.
REQ-005 Ports: enable  in  1  permits starting a new block.
REQ-006 Ports: ififo_empty  in  1  input FIFO empty.
REQ-007 Ports: ififo_rd_en  out  1  input FIFO read strobe.
REQ-008 Ports: ififo_rdata  in  32  input FIFO data, valid the cycle after ififo_rd_en.
REQ-009 Ports: aes_start  out  1  one-cycle start pulse to AES core.
REQ-010 Ports: aes_din  out  128  assembled plaintext block.
REQ-011 Ports: aes_done  in  1  one-cycle completion pulse from AES core.
REQ-012 Ports: aes_dout  in  128  ciphertext, valid while aes_done=1.
REQ-013 Ports: ofifo_full  in  1  output FIFO full.
REQ-014 Ports: ofifo_wr_en  out  1  output FIFO write strobe.
REQ-015 Ports: ofifo_wdata  out  32  output FIFO write data.
REQ-016 Ports: busy  out  1  high whenever state != IDLE.
REQ-017 Ports: blk_cnt  out  CNT_W  completed-block counter.
REQ-018 Ports: err_timeout  out  1  sticky AES timeout flag.

Function
REQ-019 FSM states IDLE, LOAD, START, WAIT, DRAIN; one state register.
REQ-020 IDLE->LOAD when enable=1 and ififo_empty=0; enable is sampled only in IDLE, deassertion elsewhere does not abort the block.
REQ-021 LOAD: ififo_rd_en = !ififo_empty while fewer than 4 reads issued; never asserted when ififo_empty=1 or outside LOAD.
REQ-022 Read data captured one cycle after each rd_en; word k (k=0..3) goes to aes_din[127-32k -: 32] (first word = MSW).
REQ-023 LOAD->START on the cycle the 4th word is captured; FIFO underflow stalls LOAD indefinitely without loss of captured words.
REQ-024 START lasts exactly one cycle with aes_start=1, then ->WAIT; aes_din is held stable from START until the next LOAD capture.
REQ-025 WAIT: timeout counter cleared in START, increments each WAIT cycle; aes_done=1 captures aes_dout into a 128-bit result register and ->DRAIN.
REQ-026 WAIT: if counter reaches TIMEOUT without aes_done, set err_timeout, discard block, ->IDLE; blk_cnt unchanged.
REQ-027 aes_done outside WAIT is ignored.
REQ-028 DRAIN: ofifo_wr_en = !ofifo_full; ofifo_wdata = result word k, MSW first, k advances only on an accepted write.
REQ-029 After the 4th accepted write: blk_cnt increments by 1 (wraps modulo 2^CNT_W), ->IDLE.
REQ-030 Back-to-back blocks: IDLE dwell is exactly one cycle when enable=1 and input FIFO non-empty.
REQ-031 Minimum latency, 4 words available, ofifo not full, aes_done k cycles after aes_start: first rd_en cycle 1, aes_start cycle 6, first write cycle 7+k, last write cycle 10+k.

Reset
REQ-032 rst=1 asynchronously forces state IDLE, clears word/read counters, timeout counter, result and aes_din registers, blk_cnt=0, err_timeout=0.
REQ-033 During and immediately after reset: ififo_rd_en=0, aes_start=0, ofifo_wr_en=0, ofifo_wdata=0, busy=0.
REQ-034 err_timeout is cleared only by rst.
REQ-035 Reset mid-block discards the partial block; no further strobes issued until IDLE re-qualifies.

Verification
REQ-036 4 words 0x00112233,0x44556677,0x8899AABB,0xCCDDEEFF queued, model echoes aes_din after 10 cycles -> aes_din=0x00112233445566778899AABBCCDDEEFF, output FIFO receives same 4 words in order, blk_cnt=1.
REQ-037 Input FIFO supplies 2 words then empty for 20 cycles -> rd_en low while empty, no aes_start, completes correctly after refill.
REQ-038 ofifo_full held high 5 cycles during DRAIN -> wr_en low during those cycles, no word lost or duplicated.
REQ-039 AES model never asserts aes_done -> err_timeout=1 at TIMEOUT cycles after aes_start, state IDLE, blk_cnt unchanged; next block processes normally, err_timeout stays 1.
REQ-040 rst asserted in WAIT -> all outputs at reset values same cycle; late aes_done ignored.
REQ-041 8 blocks back-to-back with enable=1 -> blk_cnt=8, one IDLE cycle between blocks, output order matches input.

Source files
------------

// File: rtl/aes_fifo_sequencer.sv
// aes_fifo_sequencer: reads 4x32b from input FIFO, runs AES core (aes_start/aes_done, sticky err_timeout), writes 4x32b MSW-first to output FIFO, counts blocks in blk_cnt; busy when not IDLE
module aes_fifo_sequencer #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             ififo_empty,
  output logic             ififo_rd_en,
  input  logic [31:0]      ififo_rdata,
  output logic             aes_start,
  output logic [127:0]     aes_din,
  input  logic             aes_done,
  input  logic [127:0]     aes_dout,
  input  logic             ofifo_full,
  output logic             ofifo_wr_en,
  output logic [31:0]      ofifo_wdata,
  output logic             busy,
  output logic [CNT_W-1:0] blk_cnt,
  output logic             err_timeout
);
  localparam int TW = $clog2(TIMEOUT + 1);
  typedef enum logic [2:0] {IDLE, LOAD, START, WAIT, DRAIN} state_t;
  state_t state, state_nx;
  logic [2:0] rd_cnt;
  logic [1:0] wcnt;
  logic rd_q;
  logic [TW-1:0] tcnt;
  logic [127:0] res;
  logic tmo;
  assign ififo_rd_en = state == LOAD && !ififo_empty && rd_cnt != 3'd4;
  assign aes_start = state == START;
  assign ofifo_wr_en = state == DRAIN && !ofifo_full;
  assign ofifo_wdata = state == DRAIN ? res[127:96] : '0;
  assign busy = state != IDLE;
  assign tmo = state == WAIT && !aes_done && tcnt == TW'(TIMEOUT - 1);
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = enable && !ififo_empty ? LOAD : IDLE;
      LOAD:    state_nx = rd_q && wcnt == 2'd3 ? START : LOAD;
      START:   state_nx = WAIT;
      WAIT:    state_nx = aes_done ? DRAIN : tmo ? IDLE : WAIT;
      DRAIN:   state_nx = ofifo_wr_en && wcnt == 2'd3 ? IDLE : DRAIN;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      rd_cnt <= '0;
      wcnt <= '0;
      rd_q <= 1'b0;
      tcnt <= '0;
      res <= '0;
      aes_din <= '0;
      blk_cnt <= '0;
      err_timeout <= 1'b0;
    end else begin
      state <= state_nx;
      rd_q <= ififo_rd_en;
      rd_cnt <= state == IDLE ? 3'd0 : rd_cnt + 3'(ififo_rd_en);
      tcnt <= state == WAIT ? tcnt + TW'(1) : '0;
      err_timeout <= err_timeout | tmo;
      if (state == IDLE) wcnt <= '0;
      else if (rd_q || ofifo_wr_en) wcnt <= wcnt + 2'd1;
      if (rd_q) aes_din <= {aes_din[95:0], ififo_rdata};
      if (state == WAIT && aes_done) res <= aes_dout;
      else if (ofifo_wr_en) res <= {res[95:0], 32'h0};
      if (ofifo_wr_en && wcnt == 2'd3) blk_cnt <= blk_cnt + CNT_W'(1);
    end
endmodule
